// File: rtl/rvv.sv
// Minimal RVV execution slice: 32 x 64-bit vector register file feeding a
// SIMD add/sub ALU with selectable element width and a registered result.
module rvv (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  valu_op,
  input  logic [2:0]  sew_encoded_id,
  input  logic [2:0]  lmul_encoded_id,
  input  logic [7:0]  AVL,
  input  logic [4:0]  raA,
  input  logic [4:0]  raB,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  input  logic [31:0] alu_scalar_in_id,
  input  logic        wen,
  output logic [63:0] alu_res
);

  localparam int unsigned VLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NBYTE = VLEN / 8;

  localparam logic [3:0] OP_VADD_VV = 4'b0000;
  localparam logic [3:0] OP_VADD_VX = 4'b0001;
  localparam logic [3:0] OP_VSUB_VV = 4'b0010;
  localparam logic [3:0] OP_VSUB_VX = 4'b0011;

  logic [VLEN-1:0] r_regs [NREGS];
  logic [VLEN-1:0] r_alu_res;

  logic [VLEN-1:0] w_a;
  logic [VLEN-1:0] w_b;
  logic [VLEN-1:0] w_opnd;
  logic [VLEN-1:0] w_rep;
  logic [VLEN-1:0] w_raw;
  logic [VLEN-1:0] w_res;
  logic [1:0]      w_sew_sh;
  logic            w_sub;
  logic            w_vx;
  logic            w_valid;

  // LMUL is accepted for interface compatibility but never groups registers.
  logic w_unused_lmul;
  assign w_unused_lmul = ^lmul_encoded_id;

  // Register file write port; reg 0 is ordinary storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wen) begin
      r_regs[wa] <= wd;
    end
  end

  // Operand fetch and op/SEW decode.
  always_comb begin
    w_a      = r_regs[raA];
    w_b      = r_regs[raB];
    w_sub    = 1'b0;
    w_vx     = 1'b0;
    w_valid  = 1'b1;
    w_sew_sh = 2'd0;
    unique case (valu_op)
      OP_VADD_VV: ;
      OP_VADD_VX: w_vx = 1'b1;
      OP_VSUB_VV: w_sub = 1'b1;
      OP_VSUB_VX: begin w_sub = 1'b1; w_vx = 1'b1; end
      default:    w_valid = 1'b0;
    endcase
    unique case (sew_encoded_id)
      3'b010:  w_sew_sh = 2'd1;
      3'b011:  w_sew_sh = 2'd2;
      3'b100:  w_sew_sh = 2'd3;
      default: w_sew_sh = 2'd0;
    endcase
  end

  // Scalar replicated into every lane of the selected width.
  always_comb begin
    w_rep = '0;
    unique case (w_sew_sh)
      2'd0:    w_rep = {NBYTE{alu_scalar_in_id[7:0]}};
      2'd1:    w_rep = {(NBYTE/2){alu_scalar_in_id[15:0]}};
      2'd2:    w_rep = {2{alu_scalar_in_id}};
      default: w_rep = {{32{alu_scalar_in_id[31]}}, alu_scalar_in_id};
    endcase
    w_opnd = w_vx ? w_rep : w_b;
  end

  // Lane arithmetic per SEW, carries confined to each lane.
  always_comb begin
    w_raw = '0;
    unique case (w_sew_sh)
      2'd0: for (int i = 0; i < 8; i++)
              w_raw[i*8 +: 8] = w_sub ? w_a[i*8 +: 8] - w_opnd[i*8 +: 8]
                                      : w_a[i*8 +: 8] + w_opnd[i*8 +: 8];
      2'd1: for (int i = 0; i < 4; i++)
              w_raw[i*16 +: 16] = w_sub ? w_a[i*16 +: 16] - w_opnd[i*16 +: 16]
                                        : w_a[i*16 +: 16] + w_opnd[i*16 +: 16];
      2'd2: for (int i = 0; i < 2; i++)
              w_raw[i*32 +: 32] = w_sub ? w_a[i*32 +: 32] - w_opnd[i*32 +: 32]
                                        : w_a[i*32 +: 32] + w_opnd[i*32 +: 32];
      default: w_raw = w_sub ? w_a - w_opnd : w_a + w_opnd;
    endcase
  end

  // Tail masking: byte i belongs to element i>>sew_sh, active when below AVL
  // (this index never exceeds VLEN/SEW, so min(AVL, VLEN/SEW) is implicit).
  always_comb begin
    w_res = '0;
    for (int i = 0; i < NBYTE; i++) begin
      if (w_valid && (8'(i >> w_sew_sh) < AVL))
        w_res[i*8 +: 8] = w_raw[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_alu_res <= '0;
    else      r_alu_res <= w_res;
  end

  assign alu_res = r_alu_res;

endmodule

// File: tb/tb_rvv.sv
// Directed bench for rvv: hand-computed add/sub vectors across SEWs, tail
// masking, invalid ops, write/read timing and asynchronous reset.
module tb_rvv;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valu_op;
  logic [2:0]  sew_encoded_id;
  logic [2:0]  lmul_encoded_id;
  logic [7:0]  AVL;
  logic [4:0]  raA, raB, wa;
  logic [63:0] wd;
  logic [31:0] alu_scalar_in_id;
  logic        wen;
  logic [63:0] alu_res;

  int total = 0;
  int bad   = 0;

  rvv dut (
    .clk(clk), .rst(rst), .valu_op(valu_op), .sew_encoded_id(sew_encoded_id),
    .lmul_encoded_id(lmul_encoded_id), .AVL(AVL), .raA(raA), .raB(raB),
    .wa(wa), .wd(wd), .alu_scalar_in_id(alu_scalar_in_id), .wen(wen),
    .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %016h expected %016h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    wen = 1'b1; wa = a; wd = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Drive controls away from the edge, then sample just after the next edge.
  task automatic op(input string tag, input logic [3:0] o, input logic [2:0] sew,
                    input logic [7:0] avl, input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] s, input logic [63:0] exp);
    @(negedge clk);
    wen = 1'b0; valu_op = o; sew_encoded_id = sew; AVL = avl;
    raA = a; raB = b; alu_scalar_in_id = s;
    lmul_encoded_id = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    check(tag, alu_res, exp);
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; valu_op = '0; sew_encoded_id = '0; lmul_encoded_id = '0;
    AVL = '0; raA = '0; raB = '0; wa = '0; wd = '0; alu_scalar_in_id = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_res", alu_res, 64'h0);
    @(negedge clk); rst = 1'b1;

    wr(5'd2, 64'h00FF00FF00FF00FF);
    wr(5'd3, 64'hFF00FF00FF00FF00);
    op("vv_add_s8",      4'b0000, 3'b000, 8'd16, 5'd2, 5'd3, 32'h0, 64'hFFFFFFFFFFFFFFFF);
    op("vv_add_s8_tail", 4'b0000, 3'b000, 8'd3,  5'd2, 5'd3, 32'h0, 64'h0000000000FFFFFF);
    op("vv_add_sew001",  4'b0000, 3'b001, 8'd16, 5'd2, 5'd3, 32'h0, 64'hFFFFFFFFFFFFFFFF);

    wr(5'd3, 64'h0001000100010001);
    op("vv_add_s8_wrap", 4'b0000, 3'b000, 8'd16, 5'd2, 5'd3, 32'h0, 64'h0000000000000000);
    op("vv_add_s16",     4'b0000, 3'b010, 8'd16, 5'd2, 5'd3, 32'h0, 64'h0100010001000100);
    op("vv_add_sew101",  4'b0000, 3'b101, 8'd16, 5'd2, 5'd3, 32'h0, 64'h0000000000000000);
    op("vx_add_s8",      4'b0001, 3'b000, 8'd16, 5'd2, 5'd0, 32'h1, 64'h0100010001000100);
    op("vx_add_s16",     4'b0001, 3'b010, 8'd16, 5'd2, 5'd0, 32'h1, 64'h0100010001000100);
    op("vx_add_s32",     4'b0001, 3'b011, 8'd2,  5'd2, 5'd0, 32'h1, 64'h00FF010000FF0100);
    op("vx_add_s64_neg", 4'b0001, 3'b100, 8'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 64'h00FF00FF00FF00FE);
    op("vx_add_s64_vl0", 4'b0001, 3'b100, 8'd0,  5'd2, 5'd0, 32'h1, 64'h0);
    op("vx_sub_s8",      4'b0011, 3'b000, 8'd16, 5'd2, 5'd0, 32'h1, 64'hFFFEFFFEFFFEFFFE);
    op("vx_sub_s16",     4'b0011, 3'b010, 8'd16, 5'd2, 5'd0, 32'h1, 64'h00FE00FE00FE00FE);
    op("bad_op",         4'b0100, 3'b000, 8'd16, 5'd2, 5'd3, 32'h1, 64'h0);
    op("bad_op_f",       4'b1111, 3'b010, 8'd16, 5'd2, 5'd3, 32'h1, 64'h0);

    wr(5'd2, 64'h0002000200020002);
    op("vv_sub_s8",      4'b0010, 3'b000, 8'd16, 5'd2, 5'd3, 32'h0, 64'h0001000100010001);
    wr(5'd3, 64'h0003000300030003);
    op("vv_sub_s8_neg",  4'b0010, 3'b000, 8'd16, 5'd2, 5'd3, 32'h0, 64'h00FF00FF00FF00FF);
    op("vv_sub_s16",     4'b0010, 3'b010, 8'd16, 5'd2, 5'd3, 32'h0, 64'hFFFFFFFFFFFFFFFF);
    op("vv_sub_s16_vl2", 4'b0010, 3'b010, 8'd2,  5'd2, 5'd3, 32'h0, 64'h00000000FFFFFFFF);

    // Reg 0 is ordinary storage.
    wr(5'd0, 64'h0000000000000005);
    op("reg0_store",     4'b0000, 3'b100, 8'd1, 5'd0, 5'd0, 32'h0, 64'h000000000000000A);

    // Same-edge write is not visible to the ALU until the following edge.
    wr(5'd5, 64'h0000000000000010);
    @(negedge clk);
    wen = 1'b1; wa = 5'd5; wd = 64'h0000000000000020;
    valu_op = 4'b0000; sew_encoded_id = 3'b100; AVL = 8'd1; raA = 5'd5; raB = 5'd0;
    @(posedge clk); #1;
    check("no_bypass_old", alu_res, 64'h0000000000000015);
    @(negedge clk); wen = 1'b0;
    @(posedge clk); #1;
    check("no_bypass_new", alu_res, 64'h0000000000000025);

    // Asynchronous reset mid-run clears result at once and all registers.
    wr(5'd31, 64'hDEADBEEF12345678);
    op("pre_reset",      4'b0000, 3'b100, 8'd1, 5'd31, 5'd0, 32'h0, 64'hDEADBEEF1234567D);
    @(negedge clk); #2;
    rst = 1'b0;
    #1 check("async_reset", alu_res, 64'h0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 32; i++)
      op($sformatf("reg%0d_clr", i), 4'b0000, 3'b100, 8'd1, 5'(i), 5'd0, 32'h0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
